csr_req_queue: RTL and testbench

Parametrised successor to the writeback-to-CSR request path.
- Decodes CSR/system instructions at writeback into csr_cmd_t commands.
- Buffers them in a DEPTH-entry FIFO and issues them to the CSR file over a valid/ready request channel.
- Keeps one request outstanding, waits for the CSR response, then returns a registered completion (read data, exception) to writeback.

---
 rtl/csr_req_queue.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_csr_req_queue.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_req_queue.sv
// csr_req_queue
//
// Writeback-to-CSR request path. CSR/system instructions arriving from
// writeback are decoded into csr_cmd_t commands, buffered in a DEPTH-entry
// FIFO and issued one at a time to the CSR file. The queue waits for the CSR
// response and then returns a registered one-cycle completion to writeback.
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   flush_i                drop every entry not yet accepted by the CSR file
//   enq_*                  enqueue channel from writeback (op, rs1/zimm, data,
//                          CSR address, PC)
//   csr_req_*, csr_cmd_o,
//   csr_addr_o, csr_wdata_o,
//   csr_pc_o               request channel to the CSR file
//   csr_resp_*             response from the CSR file (old value, fault)
//   cmp_valid_o, cmp_rdata_o,
//   cmp_xcpt_o             one-cycle completion pulse back to writeback
//   count_o, busy_o        occupancy (including the in-flight head)
//
// Handshakes: a beat transfers on a rising clock edge where valid and ready
// are both high. Once raised, csr_req_valid_o and its fields stay stable until
// the transfer; enq_ready_o depends only on occupancy and flush_i, never on
// enq_valid_i.
//
// Optional build macro: CSR_REQ_TIMEOUT_EN adds parameter TIMEOUT_CYCLES and
// forces a faulting completion when the CSR file never answers.
// Optional macro ASSERTIONS enables the protocol assertion.

package csr_req_queue_pkg;
    typedef enum logic [2:0] {
        CSR_CMD_NOPE  = 3'd0,
        CSR_CMD_READ  = 3'd1,
        CSR_CMD_WRITE = 3'd2,
        CSR_CMD_SET   = 3'd3,
        CSR_CMD_CLEAR = 3'd4,
        CSR_CMD_RW    = 3'd5,
        CSR_CMD_SYS   = 3'd6
    } csr_cmd_t;
endpackage

module csr_req_queue
    import csr_req_queue_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int CSR_ADDR_W = 12,
    parameter int DEPTH      = 2,
    parameter int IMM_W      = 5
`ifdef CSR_REQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         flush_i,
    input  logic                         enq_valid_i,
    output logic                         enq_ready_o,
    input  logic [2:0]                   enq_op_i,
    input  logic [IMM_W-1:0]             enq_rs1_i,
    input  logic [XLEN-1:0]              enq_data_i,
    input  logic [CSR_ADDR_W-1:0]        enq_addr_i,
    input  logic [XLEN-1:0]              enq_pc_i,
    output logic                         csr_req_valid_o,
    input  logic                         csr_req_ready_i,
    output csr_cmd_t                     csr_cmd_o,
    output logic [CSR_ADDR_W-1:0]        csr_addr_o,
    output logic [XLEN-1:0]              csr_wdata_o,
    output logic [XLEN-1:0]              csr_pc_o,
    input  logic                         csr_resp_valid_i,
    input  logic [XLEN-1:0]              csr_resp_rdata_i,
    input  logic                         csr_resp_xcpt_i,
    output logic                         cmp_valid_o,
    output logic [XLEN-1:0]              cmp_rdata_o,
    output logic                         cmp_xcpt_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    req_valid_q;
    logic                    cmp_valid_q;
    logic [XLEN-1:0]         cmp_rdata_q;
    logic                    cmp_xcpt_q;

    csr_cmd_t                cmd_mem   [DEPTH];
    logic [CSR_ADDR_W-1:0]   addr_mem  [DEPTH];
    logic [XLEN-1:0]         wdata_mem [DEPTH];
    logic [XLEN-1:0]         pc_mem    [DEPTH];

    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    // ---------------- decode ----------------
    csr_cmd_t                dec_cmd;
    logic [XLEN-1:0]         dec_wdata;
    logic                    dec_keep;
    logic                    rs1_zero;
    logic [XLEN-1:0]         zimm;

    assign rs1_zero = (enq_rs1_i == '0);
    assign zimm     = {{(XLEN-IMM_W){1'b0}}, enq_rs1_i};

    always_comb begin
        dec_cmd   = CSR_CMD_NOPE;
        dec_wdata = enq_data_i;
        dec_keep  = 1'b1;
        case (enq_op_i)
            3'd0: dec_cmd = rs1_zero ? CSR_CMD_WRITE : CSR_CMD_RW;
            3'd1: dec_cmd = rs1_zero ? CSR_CMD_READ  : CSR_CMD_SET;
            3'd2: dec_cmd = rs1_zero ? CSR_CMD_READ  : CSR_CMD_CLEAR;
            3'd3: begin
                dec_cmd   = rs1_zero ? CSR_CMD_WRITE : CSR_CMD_RW;
                dec_wdata = zimm;
            end
            3'd4: begin
                dec_cmd   = rs1_zero ? CSR_CMD_READ : CSR_CMD_SET;
                dec_wdata = zimm;
            end
            3'd5: begin
                dec_cmd   = rs1_zero ? CSR_CMD_READ : CSR_CMD_CLEAR;
                dec_wdata = zimm;
            end
            3'd6: begin
                dec_cmd   = CSR_CMD_SYS;
                dec_wdata = '0;
            end
            // Reserved op: the beat is consumed but never stored.
            default: dec_keep = 1'b0;
        endcase
    end

    // ---------------- handshakes ----------------
    logic push, req_hs, resp_take, timeout_fire, pop, head_claimed;

    assign enq_ready_o  = (count_q < CNT_W'(DEPTH)) && !flush_i;
    assign push         = enq_valid_i && enq_ready_o && dec_keep;
    assign req_hs       = (state_q == ST_REQ) && csr_req_ready_i;
    assign resp_take    = (state_q == ST_WAIT) && csr_resp_valid_i;
    assign pop          = resp_take || timeout_fire;
    // The head survives a flush once the CSR file has accepted it, including
    // when the acceptance and the flush land on the same edge.
    assign head_claimed = (state_q == ST_WAIT) || req_hs;

`ifdef CSR_REQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] wait_cnt_q;

    // Fires in the TIMEOUT_CYCLES-th WAIT cycle; a response in that same
    // cycle still wins.
    assign timeout_fire = (state_q == ST_WAIT) && !csr_resp_valid_i &&
                          (wait_cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wait_cnt_q <= '0;
        end else if (state_q != ST_WAIT || pop) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + TMR_W'(1);
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    // ---------------- pointers and occupancy ----------------
    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        if (flush_i) begin
            // Keep at most the accepted head; everything behind it is dropped.
            wr_ptr_d = rd_ptr_q + PTR_W'(head_claimed);
            count_d  = CNT_W'(head_claimed) - CNT_W'(pop);
        end else begin
            wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            cmd_mem[wr_ptr_q]   <= dec_cmd;
            addr_mem[wr_ptr_q]  <= enq_addr_i;
            wdata_mem[wr_ptr_q] <= dec_wdata;
            pc_mem[wr_ptr_q]    <= enq_pc_i;
        end
    end

    // ---------------- issue / completion FSM ----------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_rdata_q <= '0;
            cmp_xcpt_q  <= 1'b0;
        end else begin
            cmp_valid_q <= pop;
            if (resp_take) begin
                cmp_rdata_q <= csr_resp_rdata_i;
                cmp_xcpt_q  <= csr_resp_xcpt_i;
            end else if (timeout_fire) begin
                cmp_rdata_q <= '0;
                cmp_xcpt_q  <= 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (count_d != '0) begin
                        state_q     <= ST_REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (req_hs) begin
                        state_q     <= ST_WAIT;
                        req_valid_q <= 1'b0;
                    end else if (flush_i) begin
                        state_q     <= ST_IDLE;
                        req_valid_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (pop) begin
                        if (count_d != '0) begin
                            state_q     <= ST_REQ;
                            req_valid_q <= 1'b1;
                        end else begin
                            state_q     <= ST_IDLE;
                            req_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Request fields read straight from the head slot; the slot cannot be
    // overwritten while it is occupied, so they are stable during REQ.
    assign csr_req_valid_o = req_valid_q;
    assign csr_cmd_o       = req_valid_q ? cmd_mem[rd_ptr_q]   : CSR_CMD_NOPE;
    assign csr_addr_o      = req_valid_q ? addr_mem[rd_ptr_q]  : '0;
    assign csr_wdata_o     = req_valid_q ? wdata_mem[rd_ptr_q] : '0;
    assign csr_pc_o        = req_valid_q ? pc_mem[rd_ptr_q]    : '0;

    assign cmp_valid_o = cmp_valid_q;
    assign cmp_rdata_o = cmp_rdata_q;
    assign cmp_xcpt_o  = cmp_xcpt_q;
    assign count_o     = count_q;
    assign busy_o      = (count_q != '0);

`ifdef ASSERTIONS
    a_resp_only_in_wait: assert property (
        @(posedge clk_i) disable iff (!rstn_i)
        csr_resp_valid_i |-> (state_q == ST_WAIT)
    );
`endif

endmodule

// File: tb/tb_csr_req_queue.sv
module tb_csr_req_queue;
    import csr_req_queue_pkg::*;

    localparam int XLEN  = 64;
    localparam int AW    = 12;
    localparam int DEPTH = 2;
    localparam int IMM_W = 5;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              clk_i, rstn_i, flush_i;
    logic              enq_valid_i, enq_ready_o;
    logic [2:0]        enq_op_i;
    logic [IMM_W-1:0]  enq_rs1_i;
    logic [XLEN-1:0]   enq_data_i, enq_pc_i;
    logic [AW-1:0]     enq_addr_i;
    logic              csr_req_valid_o, csr_req_ready_i;
    csr_cmd_t          csr_cmd_o;
    logic [AW-1:0]     csr_addr_o;
    logic [XLEN-1:0]   csr_wdata_o, csr_pc_o;
    logic              csr_resp_valid_i, csr_resp_xcpt_i;
    logic [XLEN-1:0]   csr_resp_rdata_i;
    logic              cmp_valid_o, cmp_xcpt_o;
    logic [XLEN-1:0]   cmp_rdata_o;
    logic [CNT_W-1:0]  count_o;
    logic              busy_o;

    csr_req_queue #(.XLEN(XLEN), .CSR_ADDR_W(AW), .DEPTH(DEPTH), .IMM_W(IMM_W)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o), .enq_op_i(enq_op_i),
        .enq_rs1_i(enq_rs1_i), .enq_data_i(enq_data_i), .enq_addr_i(enq_addr_i),
        .enq_pc_i(enq_pc_i), .csr_req_valid_o(csr_req_valid_o),
        .csr_req_ready_i(csr_req_ready_i), .csr_cmd_o(csr_cmd_o),
        .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o), .csr_pc_o(csr_pc_o),
        .csr_resp_valid_i(csr_resp_valid_i), .csr_resp_rdata_i(csr_resp_rdata_i),
        .csr_resp_xcpt_i(csr_resp_xcpt_i), .cmp_valid_o(cmp_valid_o),
        .cmp_rdata_o(cmp_rdata_o), .cmp_xcpt_o(cmp_xcpt_o), .count_o(count_o),
        .busy_o(busy_o)
    );

    // ---------------- clock ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        csr_cmd_t          cmd;
        logic [AW-1:0]     addr;
        logic [XLEN-1:0]   wdata;
        logic [XLEN-1:0]   pc;
    } req_t;

    req_t              pend_q[$];   // accepted, not yet taken by the CSR file
    logic [XLEN:0]     exp_q[$];    // expected completions {xcpt, rdata}
    bit                inflight = 0;
    bit                exp_req_valid = 0;
    bit                cmp_due = 0;
    bit                hs_evt = 0;

    function automatic bit model_decode(input logic [2:0] op, input logic [IMM_W-1:0] rs1,
                                        input logic [XLEN-1:0] data, input logic [AW-1:0] addr,
                                        input logic [XLEN-1:0] pc, output req_t r);
        logic [XLEN-1:0] zimm;
        zimm = '0;
        zimm[IMM_W-1:0] = rs1;
        r.addr  = addr;
        r.pc    = pc;
        r.wdata = (op >= 3'd3) ? zimm : data;
        r.cmd   = CSR_CMD_NOPE;
        case (op)
            3'd0, 3'd3: r.cmd = (rs1 == 0) ? CSR_CMD_WRITE : CSR_CMD_RW;
            3'd1, 3'd4: r.cmd = (rs1 == 0) ? CSR_CMD_READ  : CSR_CMD_SET;
            3'd2, 3'd5: r.cmd = (rs1 == 0) ? CSR_CMD_READ  : CSR_CMD_CLEAR;
            3'd6: begin
                r.cmd   = CSR_CMD_SYS;
                r.wdata = '0;
            end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk_i or negedge rstn_i);
            if (!rstn_i) begin
                pend_q.delete();
                exp_q.delete();
                inflight      = 0;
                exp_req_valid = 0;
                cmp_due       = 0;
                hs_evt        = 0;
            end else begin
                int   occ;
                bit   rdy;
                req_t r;
                occ     = pend_q.size() + int'(inflight);
                rdy     = (occ < DEPTH) && !flush_i;
                cmp_due = 0;
                if (inflight && csr_resp_valid_i) begin
                    exp_q.push_back({csr_resp_xcpt_i, csr_resp_rdata_i});
                    inflight = 0;
                    cmp_due  = 1;
                end else if (exp_req_valid && csr_req_ready_i) begin
                    void'(pend_q.pop_front());
                    inflight = 1;
                    hs_evt   = 1;
                end
                if (flush_i) begin
                    pend_q.delete();
                end else if (enq_valid_i && rdy &&
                             model_decode(enq_op_i, enq_rs1_i, enq_data_i, enq_addr_i, enq_pc_i, r)) begin
                    pend_q.push_back(r);
                end
                exp_req_valid = !inflight && (pend_q.size() > 0);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            int occ;
            @(negedge clk_i);
            #2;
            occ = pend_q.size() + int'(inflight);
            chk("count", 64'(count_o), 64'(occ));
            chk("busy", 64'(busy_o), 64'(occ != 0));
            chk("enq_ready", 64'(enq_ready_o), 64'((occ < DEPTH) && !flush_i));
            chk("req_valid", 64'(csr_req_valid_o), 64'(exp_req_valid));
            if (exp_req_valid && csr_req_valid_o) begin
                chk("req_cmd",   64'(csr_cmd_o),   64'(pend_q[0].cmd));
                chk("req_addr",  64'(csr_addr_o),  64'(pend_q[0].addr));
                chk("req_wdata", csr_wdata_o,      pend_q[0].wdata);
                chk("req_pc",    csr_pc_o,         pend_q[0].pc);
            end
            chk("cmp_valid", 64'(cmp_valid_o), 64'(cmp_due));
            if (cmp_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("cmp_unexpected", 64'(cmp_valid_o), 64'(0));
                end else begin
                    logic [XLEN:0] e;
                    e = exp_q.pop_front();
                    chk("cmp_rdata", cmp_rdata_o, e[XLEN-1:0]);
                    chk("cmp_xcpt", 64'(cmp_xcpt_o), 64'(e[XLEN]));
                end
            end
        end
    end

    // ---------------- CSR file responder ----------------
    int              ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
    int              fixed_delay = 0;  // -1 selects a random delay
    bit              hold_resp = 0;
    bit              inject_spurious = 0;
    bit              force_data_en = 0;
    logic [XLEN-1:0] force_data = '0;
    bit              rsp_pending = 0;
    int              rsp_cnt = 0;

    initial begin
        csr_req_ready_i  = 1'b0;
        csr_resp_valid_i = 1'b0;
        csr_resp_rdata_i = '0;
        csr_resp_xcpt_i  = 1'b0;
        forever begin
            @(negedge clk_i);
            csr_resp_valid_i = 1'b0;
            if (!rstn_i) begin
                rsp_pending = 0;
                hs_evt      = 0;
            end else begin
                if (hs_evt) begin
                    hs_evt      = 0;
                    rsp_pending = 1;
                    rsp_cnt     = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                end
                if (rsp_pending && !hold_resp) begin
                    if (rsp_cnt == 0) begin
                        csr_resp_valid_i = 1'b1;
                        csr_resp_rdata_i = force_data_en ? force_data : {$urandom, $urandom};
                        csr_resp_xcpt_i  = force_data_en ? 1'b0 : ($urandom_range(0, 7) == 0);
                        rsp_pending      = 0;
                    end else begin
                        rsp_cnt--;
                    end
                end else if (inject_spurious && !rsp_pending) begin
                    csr_resp_valid_i = 1'b1;
                    csr_resp_rdata_i = {$urandom, $urandom};
                    csr_resp_xcpt_i  = 1'b1;
                    inject_spurious  = 0;
                end
            end
            case (ready_mode)
                0:       csr_req_ready_i = 1'($urandom_range(0, 1));
                1:       csr_req_ready_i = 1'b1;
                default: csr_req_ready_i = 1'b0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic enq_beat(input logic [2:0] op, input logic [IMM_W-1:0] rs1,
                            input logic [XLEN-1:0] data, input logic [AW-1:0] addr,
                            input logic [XLEN-1:0] pc);
        enq_valid_i = 1'b1;
        enq_op_i    = op;
        enq_rs1_i   = rs1;
        enq_data_i  = data;
        enq_addr_i  = addr;
        enq_pc_i    = pc;
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        enq_valid_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < max_cycles) begin
            @(negedge clk_i);
            n++;
        end
        chk("wait_idle_busy", 64'(busy_o), 64'(0));
        repeat (3) @(negedge clk_i);
    endtask

    task automatic wait_inflight(input int max_cycles);
        int n;
        n = 0;
        while (!inflight && n < max_cycles) begin
            @(negedge clk_i);
            n++;
        end
        chk("wait_inflight", 64'(inflight), 64'(1));
    endtask

    task automatic wait_cmp(input int max_cycles);
        int n;
        n = 0;
        #1;
        while (cmp_valid_o !== 1'b1 && n < max_cycles) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("wait_cmp", 64'(cmp_valid_o), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_enq_ready"}, 64'(enq_ready_o), 64'(1));
        chk({tag, "_req_valid"}, 64'(csr_req_valid_o), 64'(0));
        chk({tag, "_cmd"},       64'(csr_cmd_o), 64'(CSR_CMD_NOPE));
        chk({tag, "_addr"},      64'(csr_addr_o), 64'(0));
        chk({tag, "_wdata"},     csr_wdata_o, 64'(0));
        chk({tag, "_pc"},        csr_pc_o, 64'(0));
        chk({tag, "_cmp_valid"}, 64'(cmp_valid_o), 64'(0));
        chk({tag, "_cmp_rdata"}, cmp_rdata_o, 64'(0));
        chk({tag, "_cmp_xcpt"},  64'(cmp_xcpt_o), 64'(0));
        chk({tag, "_count"},     64'(count_o), 64'(0));
        chk({tag, "_busy"},      64'(busy_o), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn_i      = 1'b0;
        flush_i     = 1'b0;
        enq_valid_i = 1'b0;
        enq_op_i    = '0;
        enq_rs1_i   = '0;
        enq_data_i  = '0;
        enq_addr_i  = '0;
        enq_pc_i    = '0;
        repeat (3) @(negedge clk_i);
        #1;
        check_reset_outputs("rst");
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);

        // Read-only CSRRS: latency enqueue N -> request N+1 -> completion N+3.
        force_data_en = 1;
        force_data    = 64'h8;
        enq_beat(3'd1, 5'd0, 64'hdead_beef, 12'h300, 64'h1000);
        idle_inputs();
        #1;
        chk("t1_req_valid_n1", 64'(csr_req_valid_o), 64'(1));
        chk("t1_cmd", 64'(csr_cmd_o), 64'(CSR_CMD_READ));
        chk("t1_addr", 64'(csr_addr_o), 64'h300);
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        chk("t1_cmp_valid_n3", 64'(cmp_valid_o), 64'(1));
        chk("t1_cmp_rdata", cmp_rdata_o, 64'h8);
        force_data_en = 0;
        wait_idle(50);

        // CSRRWI rs1=5 then CSRRC rs1=3 back-to-back.
        enq_beat(3'd3, 5'd5, 64'h1234, 12'h340, 64'h2000);
        #1;
        chk("t2_first_cmd", 64'(csr_cmd_o), 64'(CSR_CMD_RW));
        chk("t2_first_wdata", csr_wdata_o, 64'h5);
        enq_beat(3'd2, 5'd3, 64'hF0, 12'h341, 64'h2004);
        idle_inputs();
        #1;
        chk("t2_count_peak", 64'(count_o), 64'(2));
        @(negedge clk_i);
        #1;
        chk("t2_second_cmd", 64'(csr_cmd_o), 64'(CSR_CMD_CLEAR));
        chk("t2_second_wdata", csr_wdata_o, 64'hF0);
        wait_idle(50);

        // Full queue with the CSR file stalled.
        ready_mode = 2;
        @(negedge clk_i);
        enq_beat(3'd0, 5'd1, 64'h11, 12'h001, 64'h3000);
        enq_beat(3'd4, 5'd7, 64'h22, 12'h002, 64'h3004);
        enq_valid_i = 1'b1;
        enq_op_i    = 3'd6;
        #1;
        chk("t3_full_enq_ready", 64'(enq_ready_o), 64'(0));
        @(negedge clk_i);
        idle_inputs();
        repeat (4) @(negedge clk_i);
        ready_mode = 1;
        wait_idle(50);

        // Flush with one in WAIT and one queued behind it.
        hold_resp = 1;
        enq_beat(3'd1, 5'd2, 64'h33, 12'h010, 64'h4000);
        enq_beat(3'd5, 5'd9, 64'h44, 12'h011, 64'h4004);
        idle_inputs();
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        chk("t4_count_after_flush", 64'(count_o), 64'(1));
        repeat (3) @(negedge clk_i);
        hold_resp = 0;
        wait_cmp(20);
        wait_idle(50);
        chk("t4_busy_done", 64'(busy_o), 64'(0));

        // Asynchronous reset while waiting for a response.
        hold_resp = 1;
        enq_beat(3'd0, 5'd0, 64'h55, 12'h020, 64'h5000);
        idle_inputs();
        wait_inflight(20);
        #1;
        rstn_i = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        @(negedge clk_i);
        rstn_i = 1'b1;
        hold_resp = 0;
        inject_spurious = 1;
        repeat (5) @(negedge clk_i);
        #1;
        chk("t5_no_cmp", 64'(cmp_valid_o), 64'(0));
        chk("t5_count", 64'(count_o), 64'(0));
        @(negedge clk_i);

        // Randomised traffic.
        ready_mode  = 0;
        fixed_delay = -1;
        for (int i = 0; i < 2500; i++) begin
            enq_valid_i = 1'($urandom_range(0, 1));
            enq_op_i    = 3'($urandom_range(0, 7));
            enq_rs1_i   = ($urandom_range(0, 3) == 0) ? '0 : IMM_W'($urandom);
            enq_data_i  = {$urandom, $urandom};
            enq_addr_i  = AW'($urandom);
            enq_pc_i    = {$urandom, $urandom};
            flush_i     = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) inject_spurious = 1;
            @(negedge clk_i);
        end
        idle_inputs();
        ready_mode = 1;
        wait_idle(100);
        chk("final_exp_q_empty", 64'(exp_q.size()), 64'(0));
        chk("final_pend_q_empty", 64'(pend_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
